mm_job_sequencer: RTL and testbench

- Host-facing control block upstream of the DDR/BRAM DMA master and the compute array.
- Provides an Avalon-MM slave CSR bank where software programs the A/B/C DDR base addresses and beat lengths.
- After START, it runs one matrix-multiply job: load A, load B, compute, store C.
- It reports completion through a sticky status bit, an optional level interrupt and a job cycle counter.

---
 rtl/mm_job_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_mm_job_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_job_sequencer.sv
// CSR-programmed sequencer for one matrix-multiply job: load A, load B, compute, store C.
// Reports completion through sticky status bits, a level interrupt and a job cycle counter.
module mm_job_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int LENGTH_W  = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                avs_readdatavalid,
    output logic                start_load_a,
    output logic                start_load_b,
    output logic                start_store_c,
    output logic [ADDR_W-1:0]   base_addr_a,
    output logic [ADDR_W-1:0]   base_addr_b,
    output logic [ADDR_W-1:0]   base_addr_c,
    output logic [LENGTH_W-1:0] length_a,
    output logic [LENGTH_W-1:0] length_b,
    output logic [LENGTH_W-1:0] length_c,
    input  logic                done_load_a,
    input  logic                done_load_b,
    input  logic                done_store_c,
    output logic                compute_start,
    input  logic                compute_done,
    output logic                irq
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_COMPUTE = 3'd3,
        S_STORE_C = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Abort fires on the edge that would take the watchdog to all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t                 state;
    logic                   busy;
    logic                   done_st;
    logic                   err_st;
    logic                   irq_en;
    logic [31:0]            cycles;
    logic [TIMEOUT_W-1:0]   wd;
    logic                   wr_ctrl;
    logic                   wr_status;
    logic                   go;
    logic                   phase_ack;
    logic [31:0]            rd_mux;

    assign wr_ctrl   = avs_write && (avs_address == 4'd0);
    assign wr_status = avs_write && (avs_address == 4'd1);
    assign go        = wr_ctrl && avs_writedata[0] && !busy;
    assign irq       = done_st & irq_en;

    always_comb begin
        phase_ack = 1'b0;
        case (state)
            S_LOAD_A:  phase_ack = done_load_a  || (length_a == '0);
            S_LOAD_B:  phase_ack = done_load_b  || (length_b == '0);
            S_COMPUTE: phase_ack = compute_done;
            S_STORE_C: phase_ack = done_store_c || (length_c == '0);
            default:   phase_ack = 1'b0;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            4'd0:    rd_mux = {30'd0, irq_en, 1'b0};
            4'd1:    rd_mux = {25'd0, state, 1'b0, err_st, done_st, busy};
            4'd2:    rd_mux = 32'(base_addr_a);
            4'd3:    rd_mux = 32'(base_addr_b);
            4'd4:    rd_mux = 32'(base_addr_c);
            4'd5:    rd_mux = 32'(length_a);
            4'd6:    rd_mux = 32'(length_b);
            4'd7:    rd_mux = 32'(length_c);
            4'd8:    rd_mux = cycles;
            default: rd_mux = '0;
        endcase
    end

    // Configuration registers are frozen while a job runs; IRQ_EN stays writable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_addr_a       <= '0;
            base_addr_b       <= '0;
            base_addr_c       <= '0;
            length_a          <= '0;
            length_b          <= '0;
            length_c          <= '0;
            irq_en            <= 1'b0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read)
                avs_readdata <= rd_mux;
            if (wr_ctrl)
                irq_en <= avs_writedata[1];
            if (avs_write && !busy) begin
                case (avs_address)
                    4'd2:    base_addr_a <= avs_writedata[ADDR_W-1:0];
                    4'd3:    base_addr_b <= avs_writedata[ADDR_W-1:0];
                    4'd4:    base_addr_c <= avs_writedata[ADDR_W-1:0];
                    4'd5:    length_a    <= avs_writedata[LENGTH_W-1:0];
                    4'd6:    length_b    <= avs_writedata[LENGTH_W-1:0];
                    4'd7:    length_c    <= avs_writedata[LENGTH_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done_st       <= 1'b0;
            err_st        <= 1'b0;
            cycles        <= '0;
            wd            <= '0;
            start_load_a  <= 1'b0;
            start_load_b  <= 1'b0;
            compute_start <= 1'b0;
            start_store_c <= 1'b0;
        end else begin
            start_load_a  <= 1'b0;
            start_load_b  <= 1'b0;
            compute_start <= 1'b0;
            start_store_c <= 1'b0;
            if (busy && (cycles != '1))
                cycles <= cycles + 32'd1;
            if (wr_status) begin
                if (avs_writedata[1]) done_st <= 1'b0;
                if (avs_writedata[2]) err_st  <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state        <= S_LOAD_A;
                        busy         <= 1'b1;
                        done_st      <= 1'b0;
                        err_st       <= 1'b0;
                        cycles       <= '0;
                        wd           <= '0;
                        start_load_a <= (length_a != '0);
                    end
                end
                S_LOAD_A, S_LOAD_B, S_COMPUTE, S_STORE_C: begin
                    wd <= wd + 1'b1;
                    if (phase_ack) begin
                        wd <= '0;
                        case (state)
                            S_LOAD_A: begin
                                state        <= S_LOAD_B;
                                start_load_b <= (length_b != '0);
                            end
                            S_LOAD_B: begin
                                state         <= S_COMPUTE;
                                compute_start <= 1'b1;
                            end
                            S_COMPUTE: begin
                                state         <= S_STORE_C;
                                start_store_c <= (length_c != '0);
                            end
                            default: state <= S_DONE;
                        endcase
                    end else if (wd == WD_LAST) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        err_st <= 1'b1;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    done_st <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_job_sequencer.sv
// Bench for mm_job_sequencer: CSR vector table, DMA/compute responder model and job scenarios.
module tb_mm_job_sequencer;

    localparam int DLY = 10;

    logic        clk;
    logic        rst_n;
    logic [3:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        start_load_a, start_load_b, start_store_c, compute_start;
    logic [31:0] base_addr_a, base_addr_b, base_addr_c;
    logic [7:0]  length_a, length_b, length_c;
    logic        done_load_a, done_load_b, done_store_c, compute_done;
    logic        irq;

    // Responder outputs (model) and stray-pulse injectors (stimulus) are kept apart.
    logic m_a, m_b, m_c, m_k;
    logic s_a, s_c;
    bit   cmp_en;

    assign done_load_a  = m_a | s_a;
    assign done_load_b  = m_b;
    assign done_store_c = m_c | s_c;
    assign compute_done = m_k;

    mm_job_sequencer #(.ADDR_W(32), .LENGTH_W(8), .TIMEOUT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .start_load_a(start_load_a), .start_load_b(start_load_b), .start_store_c(start_store_c),
        .base_addr_a(base_addr_a), .base_addr_b(base_addr_b), .base_addr_c(base_addr_c),
        .length_a(length_a), .length_b(length_b), .length_c(length_c),
        .done_load_a(done_load_a), .done_load_b(done_load_b), .done_store_c(done_store_c),
        .compute_start(compute_start), .compute_done(compute_done), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMA / compute responder: a done pulse DLY cycles after each start pulse.
    int cd_a, cd_b, cd_c, cd_k;
    int plog[$];
    int width_err;
    logic pa, pb, pc, pk;

    always @(negedge clk) begin
        if (!rst_n) begin
            cd_a = 0; cd_b = 0; cd_c = 0; cd_k = 0;
            m_a = 0; m_b = 0; m_c = 0; m_k = 0;
            pa = 0; pb = 0; pc = 0; pk = 0;
        end else begin
            m_a = 0; m_b = 0; m_c = 0; m_k = 0;
            if (cd_a > 0) begin cd_a--; m_a = (cd_a == 0); end
            if (cd_b > 0) begin cd_b--; m_b = (cd_b == 0); end
            if (cd_c > 0) begin cd_c--; m_c = (cd_c == 0); end
            if (cd_k > 0) begin cd_k--; m_k = (cd_k == 0); end
            if (start_load_a)  begin plog.push_back(1); cd_a = DLY; end
            if (start_load_b)  begin plog.push_back(2); cd_b = DLY; end
            if (compute_start) begin plog.push_back(3); if (cmp_en) cd_k = DLY; end
            if (start_store_c) begin plog.push_back(4); cd_c = DLY; end
            if ((start_load_a && pa) || (start_load_b && pb) ||
                (compute_start && pk) || (start_store_c && pc))
                width_err++;
            pa = start_load_a; pb = start_load_b; pk = compute_start; pc = start_store_c;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic [3:0] addr; logic [31:0] exp; } rd_exp_t;
    rd_exp_t sb[$];

    typedef struct { bit wr; bit rd; logic [3:0] addr; logic [31:0] data; logic [31:0] exp; } vec_t;
    vec_t tbl[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic csr_access(input bit wr, input bit rd, input logic [3:0] addr,
                              input logic [31:0] data, input logic [31:0] exp);
        rd_exp_t e;
        avs_address = addr; avs_writedata = data; avs_write = wr; avs_read = rd;
        if (rd) sb.push_back('{addr, exp});
        @(posedge clk); #1;
        avs_write = 1'b0; avs_read = 1'b0;
        if (rd) begin
            @(negedge clk);
            check("rd_valid", {31'd0, avs_readdatavalid}, 32'd1);
            e = sb.pop_front();
            if (avs_readdatavalid === 1'b1)
                check($sformatf("rd_addr%0d", e.addr), avs_readdata, e.exp);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        csr_access(1'b1, 1'b0, addr, data, 32'd0);
    endtask

    task automatic rd(input logic [3:0] addr, input logic [31:0] exp);
        csr_access(1'b0, 1'b1, addr, 32'd0, exp);
    endtask

    task automatic wait_pulse(input int sel, input int max, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            case (sel)
                0:       seen = start_load_a;
                1:       seen = start_load_b;
                2:       seen = compute_start;
                default: seen = start_store_c;
            endcase
        end
        check(nm, {31'd0, seen}, 32'd1);
    endtask

    function automatic int seq_since(input int from);
        int v = 0;
        for (int i = from; i < plog.size(); i++) v = v * 10 + plog[i];
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck, want finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int snap;
        rst_n = 1'b0; avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
        s_a = 0; s_c = 0; cmp_en = 1; width_err = 0;

        tbl.push_back('{1, 0, 4'd2, 32'h0000_1000, 32'h0});
        tbl.push_back('{1, 0, 4'd3, 32'h0000_2000, 32'h0});
        tbl.push_back('{1, 0, 4'd4, 32'h0000_3000, 32'h0});
        tbl.push_back('{1, 0, 4'd5, 32'hFFFF_FF04, 32'h0});
        tbl.push_back('{1, 0, 4'd6, 32'h0000_0004, 32'h0});
        tbl.push_back('{1, 0, 4'd7, 32'h0000_0004, 32'h0});
        tbl.push_back('{1, 0, 4'd9, 32'h0000_1234, 32'h0});
        tbl.push_back('{1, 0, 4'd8, 32'h0000_0055, 32'h0});
        tbl.push_back('{0, 1, 4'd2, 32'h0, 32'h0000_1000});
        tbl.push_back('{0, 1, 4'd3, 32'h0, 32'h0000_2000});
        tbl.push_back('{0, 1, 4'd4, 32'h0, 32'h0000_3000});
        tbl.push_back('{0, 1, 4'd5, 32'h0, 32'h0000_0004});
        tbl.push_back('{0, 1, 4'd6, 32'h0, 32'h0000_0004});
        tbl.push_back('{0, 1, 4'd7, 32'h0, 32'h0000_0004});
        tbl.push_back('{0, 1, 4'd9, 32'h0, 32'h0});
        tbl.push_back('{0, 1, 4'd8, 32'h0, 32'h0});
        tbl.push_back('{0, 1, 4'd0, 32'h0, 32'h0});
        tbl.push_back('{0, 1, 4'd1, 32'h0, 32'h0});

        repeat (3) @(negedge clk);
        check("rst_pulses", {28'd0, start_load_a, start_load_b, compute_start, start_store_c}, 32'd0);
        check("rst_irq_valid", {30'd0, irq, avs_readdatavalid}, 32'd0);
        check("rst_base_a", base_addr_a, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) csr_access(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].exp);
        check("port_base_b", base_addr_b, 32'h2000);
        check("port_len_a", {24'd0, length_a}, 32'd4);

        // Read and write of LEN_C in one cycle: read sees the old value.
        csr_access(1'b1, 1'b1, 4'd7, 32'd5, 32'd4);
        rd(4'd7, 32'd5);
        wr(4'd7, 32'd4);

        // Basic job with a blocked reconfiguration attempt during LOAD_B.
        n0 = plog.size();
        wr(4'd0, 32'd1);
        wait_pulse(1, 30, "job_reach_load_b");
        wr(4'd2, 32'h0000_DEAD);
        wr(4'd0, 32'd1);
        check("busy_port_base_a", base_addr_a, 32'h1000);
        repeat (45) @(negedge clk);
        check("job_pulse_order", seq_since(n0), 32'd1234);
        rd(4'd1, 32'h02);
        rd(4'd8, 32'd45);
        rd(4'd8, 32'd45);
        rd(4'd2, 32'h1000);

        // Interrupt.
        wr(4'd1, 32'h2);
        rd(4'd1, 32'h0);
        wr(4'd0, 32'h3);
        repeat (5) @(negedge clk);
        check("irq_low_busy", {31'd0, irq}, 32'd0);
        repeat (50) @(negedge clk);
        check("irq_high_done", {31'd0, irq}, 32'd1);
        rd(4'd1, 32'h02);
        rd(4'd0, 32'h02);
        wr(4'd1, 32'h2);
        check("irq_after_w1c", {31'd0, irq}, 32'd0);
        rd(4'd1, 32'h0);
        wr(4'd0, 32'h0);

        // Zero-length loads.
        wr(4'd5, 32'd0);
        wr(4'd6, 32'd0);
        wr(4'd7, 32'd2);
        n0 = plog.size();
        wr(4'd0, 32'd1);
        wait_pulse(2, 3, "zl_compute_within3");
        repeat (30) @(negedge clk);
        check("zl_pulse_order", seq_since(n0), 32'd34);
        rd(4'd1, 32'h02);

        // Watchdog on a compute that never finishes.
        cmp_en = 0;
        n0 = plog.size();
        wr(4'd0, 32'd1);
        wait_pulse(2, 3, "to_compute");
        repeat (14) @(negedge clk);
        rd(4'd1, 32'h31);
        rd(4'd1, 32'h04);
        rd(4'd8, 32'd17);
        repeat (20) @(negedge clk);
        check("to_no_store", seq_since(n0), 32'd3);
        wr(4'd1, 32'h4);
        rd(4'd1, 32'h0);
        cmp_en = 1;

        // Reset during STORE_C.
        wr(4'd5, 32'd4);
        wr(4'd6, 32'd4);
        wr(4'd7, 32'd4);
        wr(4'd0, 32'd1);
        wait_pulse(3, 60, "rst_reach_store");
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        snap = plog.size();
        repeat (40) @(negedge clk);
        check("rst_no_pulses", plog.size(), snap);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_len_c", {24'd0, length_c}, 32'd0);
        for (int a = 0; a <= 8; a++) rd(a[3:0], 32'd0);

        // Stray done pulses: one during LOAD_A, one in IDLE.
        wr(4'd5, 32'd4);
        n0 = plog.size();
        wr(4'd0, 32'd1);
        wait_pulse(0, 3, "st_load_a");
        s_c = 1'b1;
        @(posedge clk); #1;
        s_c = 1'b0;
        rd(4'd1, 32'h11);
        repeat (30) @(negedge clk);
        rd(4'd1, 32'h02);
        check("st_pulse_order", seq_since(n0), 32'd13);
        s_a = 1'b1;
        @(posedge clk); #1;
        s_a = 1'b0;
        repeat (3) @(negedge clk);
        rd(4'd1, 32'h02);
        check("st_idle_no_pulse", seq_since(n0), 32'd13);

        check("pulse_width", width_err, 32'd0);
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
